// File: rtl/img_pkg.sv
// Shared image-pipeline constants and types, also used by the downstream 3x3 filter.
package img_pkg;

  localparam int PIC_WIDTH  = 250;
  localparam int PIC_HEIGHT = 250;
  localparam int WIDTH      = 24;

  localparam int COL_W = $clog2(PIC_WIDTH);
  localparam int ROW_W = $clog2(PIC_HEIGHT);

  typedef logic [WIDTH-1:0] pixel_t;

endpackage

// File: rtl/line_buffer_3row_if.sv
// Pixel stream bundle between the image source (master) and the line buffer (slave).
interface line_buffer_3row_if
  import img_pkg::*;
#(
  parameter int WIDTH = img_pkg::WIDTH
);

  logic             valid_in;
  logic             sof;
  logic [WIDTH-1:0] din;
  logic             valid_out;
  logic [WIDTH-1:0] dout_top;
  logic [WIDTH-1:0] dout_mid;
  logic [WIDTH-1:0] dout_bot;
  logic             line_end;

  modport master (
    output valid_in, sof, din,
    input  valid_out, dout_top, dout_mid, dout_bot, line_end
  );

  modport slave (
    input  valid_in, sof, din,
    output valid_out, dout_top, dout_mid, dout_bot, line_end
  );

endinterface

// File: rtl/line_ram.sv
// One-line pixel store, single address port; rdata is the content before this edge's write.
module line_ram
  import img_pkg::*;
#(
  parameter int DEPTH = PIC_WIDTH,
  parameter int DW    = WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Array is deliberately not reset; stale lines are masked by the row gating upstream.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_buffer_3row.sv
// Raster stream to three column-aligned rows (r-2, r-1, r) for a 3x3 window stage.
// Optional build macro EDGE_REPLICATE_EN: replicate the first line so every input pixel yields an output.
module line_buffer_3row
  import img_pkg::*;
#(
  parameter int PIC_WIDTH  = img_pkg::PIC_WIDTH,
  parameter int PIC_HEIGHT = img_pkg::PIC_HEIGHT,
  parameter int WIDTH      = img_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  line_buffer_3row_if.slave  lb
);

  localparam int CW = $clog2(PIC_WIDTH);
  localparam int RW = $clog2(PIC_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

  logic [CW-1:0]    col_r, col_eff_s, col_nxt_s;
  logic [RW-1:0]    row_r, row_eff_s, row_nxt_s;
  logic             col_last_s;
  logic [WIDTH-1:0] ram0_rd_s, ram1_rd_s;
  logic [WIDTH-1:0] top_nxt_s, mid_nxt_s;
  logic             vo_nxt_s, le_nxt_s;
  logic             valid_out_r, line_end_r;
  logic [WIDTH-1:0] dout_top_r, dout_mid_r, dout_bot_r;

  // Position of the current pixel: a qualified sof forces (0,0) whatever the counters hold.
  always_comb begin
    col_eff_s = col_r;
    row_eff_s = row_r;
    if (lb.valid_in && lb.sof) begin
      col_eff_s = {CW{1'b0}};
      row_eff_s = {RW{1'b0}};
    end else begin
      col_eff_s = col_r;
      row_eff_s = row_r;
    end
  end

  // Raster advance with line and frame wrap.
  always_comb begin
    col_last_s = (col_eff_s == COL_LAST);
    col_nxt_s  = col_eff_s;
    row_nxt_s  = row_eff_s;
    if (col_last_s) begin
      col_nxt_s = {CW{1'b0}};
      if (row_eff_s == ROW_LAST) begin
        row_nxt_s = {RW{1'b0}};
      end else begin
        row_nxt_s = row_eff_s + RW'(1);
      end
    end else begin
      col_nxt_s = col_eff_s + CW'(1);
      row_nxt_s = row_eff_s;
    end
  end

  // Column/row counters advance only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (lb.valid_in) begin
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
    end
  end

  // RAM0 holds line r-1 and takes din; RAM1 holds line r-2 and takes RAM0's old word.
  line_ram #(.DEPTH(PIC_WIDTH), .DW(WIDTH)) u_ram0 (
    .clk   (clk),
    .we    (lb.valid_in),
    .addr  (col_eff_s),
    .wdata (lb.din),
    .rdata (ram0_rd_s)
  );

  line_ram #(.DEPTH(PIC_WIDTH), .DW(WIDTH)) u_ram1 (
    .clk   (clk),
    .we    (lb.valid_in),
    .addr  (col_eff_s),
    .wdata (ram0_rd_s),
    .rdata (ram1_rd_s)
  );

  // Output selection and qualification for the current pixel.
  always_comb begin
    top_nxt_s = ram1_rd_s;
    mid_nxt_s = ram0_rd_s;
    vo_nxt_s  = 1'b0;
    le_nxt_s  = 1'b0;
`ifdef EDGE_REPLICATE_EN
    vo_nxt_s = lb.valid_in;
    le_nxt_s = lb.valid_in && col_last_s;
    case (row_eff_s)
      RW'(0): begin
        top_nxt_s = lb.din;
        mid_nxt_s = lb.din;
      end
      RW'(1): begin
        top_nxt_s = ram0_rd_s;
        mid_nxt_s = ram0_rd_s;
      end
      default: begin
        top_nxt_s = ram1_rd_s;
        mid_nxt_s = ram0_rd_s;
      end
    endcase
`else
    vo_nxt_s = lb.valid_in && (row_eff_s >= RW'(2));
    le_nxt_s = vo_nxt_s && col_last_s;
`endif
  end

  // Output registers: one-cycle latency, data held across input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out_r <= 1'b0;
      line_end_r  <= 1'b0;
      dout_top_r  <= {WIDTH{1'b0}};
      dout_mid_r  <= {WIDTH{1'b0}};
      dout_bot_r  <= {WIDTH{1'b0}};
    end else begin
      valid_out_r <= vo_nxt_s;
      line_end_r  <= le_nxt_s;
      if (lb.valid_in) begin
        dout_top_r <= top_nxt_s;
        dout_mid_r <= mid_nxt_s;
        dout_bot_r <= lb.din;
      end
    end
  end

  assign lb.valid_out = valid_out_r;
  assign lb.line_end  = line_end_r;
  assign lb.dout_top  = dout_top_r;
  assign lb.dout_mid  = dout_mid_r;
  assign lb.dout_bot  = dout_bot_r;

endmodule
